// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction fetch queue between the frontend and decode. It is a
// first-word-fall-through FIFO of DEPTH {pc, instr} pairs. Decode sees the
// oldest entry combinationally. The frontend is back-pressured when the
// queue is full. A redirect (flush) empties the queue.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   fe_pc      PC of the word the frontend delivers
//   fe_instr   instruction word the frontend delivers
//   fe_valid   frontend delivers a word this cycle
//   fe_ready   queue can accept a word (not full)
//   fe_stall   stall request to the frontend (full)
//   flush      redirect; drops all buffered words and the incoming word
//   dec_stall  decode cannot accept this cycle
//   dec_valid  head entry valid (not empty)
//   dec_pc     head PC, or the last dequeued PC when empty
//   dec_instr  head instruction, or NOP_INSTR when empty
//   count      current occupancy, 0..DEPTH
//   overflow   sticky; set when fe_valid arrives while full, cleared by rst
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000033,
    parameter logic [31:0] RESET_PC  = 32'h40000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                fe_pc,
    input  logic [31:0]                fe_instr,
    input  logic                       fe_valid,
    output logic                       fe_ready,
    output logic                       fe_stall,
    input  logic                       flush,
    input  logic                       dec_stall,
    output logic                       dec_valid,
    output logic [31:0]                dec_pc,
    output logic [31:0]                dec_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   last_pc;
    logic          full;
    logic          enq;
    logic          deq;

    // Status comes only from the registered count. This keeps fe_ready free
    // of any combinational path from dec_stall. As a result, a slot freed
    // by a dequeue while full is reusable on the next cycle only.
    assign full      = (count == FULL_CNT);
    assign fe_ready  = !full;
    assign fe_stall  = full;
    assign dec_valid = (count != '0);

    assign enq = fe_valid && fe_ready && !flush;
    assign deq = dec_valid && !dec_stall;

    assign dec_pc    = dec_valid ? pc_mem[rd_ptr]    : last_pc;
    assign dec_instr = dec_valid ? instr_mem[rd_ptr] : NOP_INSTR;

    // Storage needs no reset; entries are only observable behind count.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            pc_mem[wr_ptr]    <= fe_pc;
            instr_mem[wr_ptr] <= fe_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_pc  <= RESET_PC;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Decode already consumed the head combinationally in this
            // cycle. Squashing that word is left to downstream logic.
            if (deq) begin
                last_pc <= pc_mem[rd_ptr];
            end
        end else begin
            if (fe_valid && full) begin
                overflow <= 1'b1;
            end
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr  <= rd_ptr + AW'(1);
                last_pc <= pc_mem[rd_ptr];
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] NOP_INSTR = 32'h00000033;
    localparam logic [31:0] RESET_PC  = 32'h40000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fe_pc, fe_instr;
    logic        fe_valid, fe_ready, fe_stall, flush, dec_stall;
    logic        dec_valid, overflow;
    logic [31:0] dec_pc, dec_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // The scoreboard queue holds the entries the monitor expects to see
    // dequeued. The model queue tracks occupancy and last_pc for the stimulus.
    logic [63:0] exp_q[$];
    logic [63:0] mdl_q[$];
    logic [31:0] m_last;
    logic        m_ovf;

    fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP_INSTR), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .fe_pc(fe_pc), .fe_instr(fe_instr),
        .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_stall(fe_stall),
        .flush(flush), .dec_stall(dec_stall), .dec_valid(dec_valid),
        .dec_pc(dec_pc), .dec_instr(dec_instr), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each cycle where decode takes the head, compare it with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (dec_valid === 1'b1 && dec_stall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deq_unexpected: got pc %h with empty scoreboard at %0t", dec_pc, $time);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("deq_pc", dec_pc, e[63:32]);
                    chk("deq_instr", dec_instr, e[31:0]);
                end
            end
        end
    end

    task automatic check_state();
        int n;
        n = mdl_q.size();
        chk("count", 32'(count), 32'(n));
        chk("dec_valid", 32'(dec_valid), 32'(n != 0));
        chk("fe_ready", 32'(fe_ready), 32'(n != DEPTH));
        chk("fe_stall", 32'(fe_stall), 32'(n == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (n == 0) begin
            chk("empty_pc", dec_pc, m_last);
            chk("empty_instr", dec_instr, NOP_INSTR);
        end
    endtask

    task automatic cyc(input logic fv, input logic [31:0] p, input logic [31:0] i,
                       input logic st, input logic fl, input logic r);
        logic full;
        logic do_enq;
        logic do_deq;
        fe_valid  = fv;
        fe_pc     = p;
        fe_instr  = i;
        dec_stall = st;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        check_state();
        @(posedge clk);
        if (r) begin
            mdl_q.delete();
            exp_q.delete();
            m_last = RESET_PC;
            m_ovf  = 1'b0;
        end else begin
            full   = (mdl_q.size() == DEPTH);
            do_enq = fv && !full && !fl;
            do_deq = (mdl_q.size() != 0) && !st;
            if (fv && full && !fl) m_ovf = 1'b1;
            if (do_deq) begin
                logic [63:0] h;
                h = mdl_q.pop_front();
                m_last = h[63:32];
            end
            if (fl) begin
                mdl_q.delete();
                exp_q.delete();
            end else if (do_enq) begin
                mdl_q.push_back({p, i});
                exp_q.push_back({p, i});
            end
        end
        #1;
    endtask

    task automatic idle(input logic st, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 32'h0, st, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] PCS [3]   = '{32'h40000000, 32'h40000004, 32'h40000008};
    localparam logic [31:0] INSTR [3] = '{32'h00100093, 32'h00200113, 32'h00308193};

    initial begin
        rst = 1'b1; fe_valid = 1'b0; fe_pc = '0; fe_instr = '0;
        flush = 1'b0; dec_stall = 1'b0;
        m_last = RESET_PC;
        m_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset.
        idle(1'b0, 2);

        // Three words while decode stalls, then a drain in order.
        for (int k = 0; k < 3; k++) cyc(1'b1, PCS[k], INSTR[k], 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1);
        chk("head_pc_stalled", dec_pc, 32'h40000000);
        idle(1'b0, 4);
        chk("hold_pc", dec_pc, 32'h40000008);
        chk("hold_instr", dec_instr, 32'h00000033);

        // Fill, overflow, then wrap with enqueue/dequeue pairs.
        for (int k = 0; k < DEPTH; k++)
            cyc(1'b1, 32'h40001000 + 32'(4*k), 32'hA0000000 + 32'(k), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hBADBAD00, 32'hBADBAD01, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 32'h40002000 + 32'(4*k), 32'hB0000000 + 32'(k), 1'b0, 1'b0, 1'b0);
        idle(1'b0, 4);

        // Simultaneous enqueue and dequeue at occupancy 2.
        cyc(1'b1, 32'h40003000, 32'hC0000000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h40003004, 32'hC0000001, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h40003008, 32'hC0000002, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4000300C, 32'hC0000003, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 3);

        // Flush at occupancy 3, with an incoming word in the same cycle.
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 32'h40004000 + 32'(4*k), 32'hD0000000 + 32'(k), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'h40000100, 32'hE0000000, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1);
        chk("post_flush_head", dec_pc, 32'h40000100);
        idle(1'b0, 2);

        // Reset mid-operation with occupancy 3 and overflow set.
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 32'h40005000 + 32'(4*k), 32'hF0000000 + 32'(k), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1'b0, 2);

        // Wait, with a bound, for the scoreboard to drain.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the frontend stage and the decode stage. It captures each (pc, instruction) pair the frontend delivers on an L1.5 response and buffers up to DEPTH of them in a first-word-fall-through FIFO, so decode stalls no longer freeze fetch on every cycle. The queue presents the oldest entry to decode, and back-pressures the frontend when full. It is cleared on a control-flow redirect.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- NOP_INSTR, 32'h00000033, instruction driven to decode when the queue is empty
- RESET_PC, 32'h40000000, reset value of the held decode PC

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous, active-high
- fe_pc  in  32  PC of the delivered instruction
- fe_instr  in  32  delivered instruction word
- fe_valid  in  1  frontend delivers a word this cycle (response fire)
- fe_ready  out  1  queue can accept a word; = !full
- fe_stall  out  1  stall request to frontend; = full
- flush  in  1  redirect (branch/jump/trap); discard all buffered and incoming words
- dec_stall  in  1  decode cannot accept this cycle
- dec_valid  out  1  head entry valid; = !empty
- dec_pc  out  32  head PC, or last dequeued PC when empty
- dec_instr  out  32  head instruction, or NOP_INSTR when empty
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: fe_valid seen while full

## Operation
- Storage: DEPTH × {pc[31:0], instr[31:0]}; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- enq = fe_valid && fe_ready && !flush; writes mem[wr_ptr], wr_ptr+1.
- deq = dec_valid && !dec_stall; rd_ptr+1, last_pc <= mem[rd_ptr].pc.
- count next = count + enq − deq (enq and deq in same cycle: unchanged).
- flush (priority over enq/deq): wr_ptr, rd_ptr, count <= 0 next edge; fe_valid word in flush cycle dropped. A deq in the flush cycle still updates last_pc (decode consumed it combinationally; squashing it is downstream's job).
- fe_valid while full (fe_ready=0) and !flush: word dropped, overflow <= 1; overflow cleared only by rst.
- Empty: dec_valid=0, dec_instr=NOP_INSTR, dec_pc=last_pc. No empty-bypass: enqueued word is never visible in its own enqueue cycle.
- Full: fe_ready=0, fe_stall=1; a deq in that cycle frees a slot for the next cycle only (no same-cycle enq-on-deq when full).
- Outputs dec_* are combinational from head storage/pointers (FWFT); fe_ready/fe_stall/dec_valid/count derived from registered count only.

## Timing
- Reset (rst high at posedge): wr_ptr=rd_ptr=0, count=0, last_pc=RESET_PC, overflow=0 ⇒ dec_valid=0, dec_instr=NOP_INSTR, dec_pc=RESET_PC, fe_ready=1, fe_stall=0. rst mid-operation discards all entries identically; rst overrides flush.
- Enqueue latency: word accepted at edge N appears on dec_* during cycle N+1.
- Throughput: one enq and one deq per cycle sustained; steady stream with dec_stall=0 keeps count at 1.
- Flush asserted in cycle N ⇒ dec_valid=0, count=0 in cycle N+1; first post-redirect word accepted at N+1 visible at N+2.
- Pointer wrap: after DEPTH enqueues wr_ptr returns to 0 with no loss of ordering.

## Test plan
- Reset then idle: dec_valid=0, dec_instr=32'h33, dec_pc=32'h40000000, fe_ready=1, count=0.
- Enqueue pc 0x40000000/0x40000004/0x40000008 (instr 0x00100093, 0x00200113, 0x00308193) with dec_stall=1 -> count=3, head pc 0x40000000; release dec_stall -> dequeued in order one per cycle, then dec_pc holds 0x40000008, dec_instr=0x33.
- Fill DEPTH=4 with dec_stall=1 -> fe_ready=0, fe_stall=1; extra fe_valid -> overflow=1 stays set, count=4, word discarded; 8 further enq/deq pairs verify wrap ordering.
- Simultaneous enq and deq at count=2 -> count stays 2, order preserved.
- count=3 with flush and fe_valid same cycle -> next cycle count=0, dec_valid=0, flushed word absent; next enq of pc 0x40000100 appears one cycle later.
- rst asserted at count=3, overflow=1 -> next cycle all outputs at reset values, overflow=0.
